// File: rtl/fft_result_reader_if.sv
// fft_result_reader_if: start control, RAM read port and result stream of the FFT read-out engine.
// Revision: 1.0
`default_nettype none

interface fft_result_reader_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 4
);
   logic                    start;
   logic [ADDR_WIDTH-1:0]   ram_rd_addr;
   logic                    ram_rd_en;
   logic [2*DATA_WIDTH-1:0] ram_rd_data;
   logic                    out_valid;
   logic                    out_ready;
   logic [2*DATA_WIDTH-1:0] out_data;
   logic [ADDR_WIDTH-1:0]   out_idx;
   logic                    out_last;
   logic                    busy;
   logic                    done;

   modport master (
      input  start, ram_rd_data, out_ready,
      output ram_rd_addr, ram_rd_en, out_valid, out_data, out_idx, out_last, busy, done
   );

   modport slave (
      output start, ram_rd_data, out_ready,
      input  ram_rd_addr, ram_rd_en, out_valid, out_data, out_idx, out_last, busy, done
   );
endinterface

`default_nettype wire

// File: rtl/fft_result_reader.sv
// fft_result_reader: streams N FFT result words out of the data RAM through a 2-entry skid FIFO.
// Revision: 1.0
`default_nettype none

module fft_result_reader #(
   parameter int N           = 16,
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = $clog2(N),
   parameter int BIT_REVERSE = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   fft_result_reader_if.master  bus
);

   localparam logic [ADDR_WIDTH:0]   WORD_COUNT = (ADDR_WIDTH+1)'(N);
   localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(N-1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                  state, state_nxt;
   logic [ADDR_WIDTH:0]     rd_idx;
   logic                    inflight;
   logic [ADDR_WIDTH-1:0]   inflight_idx;
   logic [2*DATA_WIDTH-1:0] fifo_data [2];
   logic [ADDR_WIDTH-1:0]   fifo_idx  [2];
   logic                    wr_ptr, rd_ptr;
   logic [1:0]              fifo_count;
   logic                    pop, push, issue;
   logic [2:0]              occupancy;
   logic [ADDR_WIDTH-1:0]   addr_nat, addr_ram;

   assign addr_nat = rd_idx[ADDR_WIDTH-1:0];

   generate
      if (BIT_REVERSE != 0) begin : g_rev
         for (genvar b = 0; b < ADDR_WIDTH; b++) begin : g_bit
            assign addr_ram[b] = addr_nat[ADDR_WIDTH-1-b];
         end
      end else begin : g_nat
         assign addr_ram = addr_nat;
      end
   endgenerate

   assign push = inflight;
   assign pop  = bus.out_valid & bus.out_ready;

   // Words already owed to the FIFO after this cycle's pop; one more read may be issued only below 2.
   assign occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};

   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      case (state)
         S_IDLE: begin
            if (bus.start) state_nxt = S_STREAM;
         end
         S_STREAM: begin
            issue = (rd_idx < WORD_COUNT) && (occupancy < 3'd2);
            if (pop && (fifo_idx[rd_ptr] == LAST_IDX)) state_nxt = S_DONE;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_idx       <= '0;
         inflight     <= 1'b0;
         inflight_idx <= '0;
         wr_ptr       <= 1'b0;
         rd_ptr       <= 1'b0;
         fifo_count   <= 2'd0;
         fifo_data[0] <= '0;
         fifo_data[1] <= '0;
         fifo_idx[0]  <= '0;
         fifo_idx[1]  <= '0;
      end else begin
         if (state == S_IDLE && bus.start) rd_idx <= '0;
         else if (issue)                    rd_idx <= rd_idx + 1'b1;
         inflight <= issue;
         if (issue) inflight_idx <= addr_nat;
         // Bin index travels with the data so out_idx stays natural order regardless of RAM addressing.
         if (push) begin
            fifo_data[wr_ptr] <= bus.ram_rd_data;
            fifo_idx[wr_ptr]  <= inflight_idx;
            wr_ptr            <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
      end
   end

   assign bus.ram_rd_addr = addr_ram;
   assign bus.ram_rd_en   = issue;
   assign bus.out_valid   = (fifo_count != 2'd0);
   assign bus.out_data    = fifo_data[rd_ptr];
   assign bus.out_idx     = fifo_idx[rd_ptr];
   assign bus.out_last    = bus.out_valid && (fifo_idx[rd_ptr] == LAST_IDX);
   assign bus.busy        = (state == S_STREAM);
   assign bus.done        = (state == S_DONE);

endmodule

`default_nettype wire

// File: tb/tb_fft_result_reader.sv
// tb_fft_result_reader: drives natural-order and bit-reversed readers side by side against a RAM/queue reference.
// Revision: 1.0
`default_nettype none

module tb_fft_result_reader;
   localparam int N  = 16;
   localparam int DW = 16;
   localparam int AW = 4;

   logic clk = 1'b0, rst = 1'b1, start = 1'b0, ready = 1'b0;
   always #5 clk = ~clk;

   fft_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus0 ();
   fft_result_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus1 ();

   assign bus0.start = start;
   assign bus1.start = start;
   assign bus0.out_ready = ready;
   assign bus1.out_ready = ready;

   fft_result_reader #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(0))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
   fft_result_reader #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BIT_REVERSE(1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

   logic [2*DW-1:0] mem [N];

   always @(posedge clk) begin
      if (bus0.ram_rd_en) bus0.ram_rd_data <= mem[bus0.ram_rd_addr];
      if (bus1.ram_rd_en) bus1.ram_rd_data <= mem[bus1.ram_rd_addr];
   end

   logic          m_valid [2], m_en [2], m_last [2], m_busy [2], m_done [2];
   logic [31:0]   m_data [2];
   logic [AW-1:0] m_idx [2], m_addr [2];
   assign m_valid[0] = bus0.out_valid;  assign m_valid[1] = bus1.out_valid;
   assign m_en[0]    = bus0.ram_rd_en;  assign m_en[1]    = bus1.ram_rd_en;
   assign m_last[0]  = bus0.out_last;   assign m_last[1]  = bus1.out_last;
   assign m_busy[0]  = bus0.busy;       assign m_busy[1]  = bus1.busy;
   assign m_done[0]  = bus0.done;       assign m_done[1]  = bus1.done;
   assign m_data[0]  = bus0.out_data;   assign m_data[1]  = bus1.out_data;
   assign m_idx[0]   = bus0.out_idx;    assign m_idx[1]   = bus1.out_idx;
   assign m_addr[0]  = bus0.ram_rd_addr; assign m_addr[1] = bus1.ram_rd_addr;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic int brev(input int k);
      int r = 0;
      for (int b = 0; b < AW; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   function automatic int ram_addr_of(input int d, input int k);
      return (d == 0) ? k : brev(k);
   endfunction

   // Reference state: words issued/accepted so far, per reader.
   int          acc [2], iss [2], done_cnt [2];
   logic        held_v [2], last_hs [2];
   logic [31:0] held_d [2];
   logic [AW-1:0] held_i [2];
   bit          mon_en = 1'b0;

   task automatic clear_model();
      for (int d = 0; d < 2; d++) begin
         acc[d] = 0; iss[d] = 0; done_cnt[d] = 0;
         held_v[d] = 1'b0; last_hs[d] = 1'b0;
      end
   endtask

   always @(negedge clk) begin
      logic pop;
      if (mon_en) begin
         for (int d = 0; d < 2; d++) begin
            pop = m_valid[d] && ready;
            if (m_en[d]) begin
               check("rd_count", 64'(iss[d] < N), 64'd1);
               check("rd_addr", 64'(m_addr[d]), 64'(ram_addr_of(d, iss[d] % N)));
               check("rd_stall", 64'((iss[d] - acc[d] - int'(pop)) < 2), 64'd1);
               iss[d]++;
            end
            if (held_v[d]) begin
               check("hold_data", 64'(m_data[d]), 64'(held_d[d]));
               check("hold_idx", 64'(m_idx[d]), 64'(held_i[d]));
            end
            if (m_done[d] || last_hs[d]) check("done_time", 64'(m_done[d]), 64'(last_hs[d]));
            if (m_done[d]) done_cnt[d]++;
            last_hs[d] = 1'b0;
            if (pop) begin
               check("out_data", 64'(m_data[d]), 64'(mem[ram_addr_of(d, acc[d] % N)]));
               check("out_idx", 64'(m_idx[d]), 64'(acc[d] % N));
               check("out_last", 64'(m_last[d]), 64'(acc[d] == N-1));
               last_hs[d] = (acc[d] == N-1);
               acc[d]++;
            end
            held_v[d] = m_valid[d] && !ready;
            held_d[d] = m_data[d];
            held_i[d] = m_idx[d];
         end
      end
   end

   task automatic run(input int mode);
      int c = 0;
      int stall = 0;
      bit extra = 1'b0;
      clear_model();
      @(posedge clk); #1;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_start", 64'(m_busy[0] & m_busy[1]), 64'd1);
      while (done_cnt[0] == 0 && c < 400) begin
         if (c <= 2) begin
            check("first_valid0", 64'(m_valid[0]), 64'(c == 2));
            check("first_valid1", 64'(m_valid[1]), 64'(c == 2));
         end
         if (mode == 0 && c >= 3 && c <= 18) check("throughput", 64'(acc[0]), 64'(c - 2));
         case (mode)
            0: ready = 1'b1;
            1: begin
               if (acc[0] == 5 && stall < 10) begin
                  ready = 1'b0;
                  stall++;
               end else begin
                  ready = (c % 4 == 0) || (c % 4 == 3);
               end
            end
            2: ready = (c % 3 == 0);
            default: ready = 1'($urandom % 2);
         endcase
         if (mode == 3 && acc[0] == 7 && !extra) begin
            start = 1'b1;
            extra = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         c++;
      end
      start = 1'b0;
      check("timeout", 64'(c < 400), 64'd1);
      ready = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("word_total", 64'(acc[d]), 64'(N));
         check("done_count", 64'(done_cnt[d]), 64'd1);
         check("busy_after", 64'(m_busy[d]), 64'd0);
         check("valid_after", 64'(m_valid[d]), 64'd0);
      end
   endtask

   task automatic reset_mid();
      int c = 0;
      clear_model();
      @(posedge clk); #1;
      start = 1'b1;
      ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      while (acc[0] < 5 && c < 100) begin
         @(posedge clk); #1;
         c++;
      end
      check("timeout_rst", 64'(c < 100), 64'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_valid", 64'(m_valid[d]), 64'd0);
         check("rst_busy", 64'(m_busy[d]), 64'd0);
         check("rst_done", 64'(m_done[d]), 64'd0);
      end
      rst = 1'b0;
      clear_model();
   endtask

   initial begin
      clear_model();
      for (int k = 0; k < N; k++) mem[k] = {16'(k * 256), 16'(-k)};
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("reset_valid", 64'(m_valid[d]), 64'd0);
         check("reset_busy", 64'(m_busy[d]), 64'd0);
         check("reset_done", 64'(m_done[d]), 64'd0);
         check("reset_rd_en", 64'(m_en[d]), 64'd0);
         check("reset_data", 64'(m_data[d]), 64'd0);
         check("reset_idx", 64'(m_idx[d]), 64'd0);
         check("reset_last", 64'(m_last[d]), 64'd0);
      end
      rst = 1'b0;
      mon_en = 1'b1;

      run(0);
      for (int k = 0; k < N; k++) mem[k] = {16'(k), 16'h0000};
      run(0);
      for (int k = 0; k < N; k++) mem[k] = $urandom;
      run(1);
      run(2);
      run(3);
      reset_mid();
      for (int k = 0; k < N; k++) mem[k] = $urandom;
      run(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
